// File: rtl/mat_pkg.sv
// Shared types and constants for the mat row streamer and its neighbours.
package mat_pkg;

    localparam int unsigned MAT_ELEM_BITS = 32;

    typedef enum logic [0:0] {
        MAT_DEST_UNIT  = 1'b0,
        MAT_DEST_CACHE = 1'b1
    } MatStreamDest_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } MatStreamState_t;

    // Index width for a set of n units; a single unit still gets one bit.
    function automatic int unsigned mat_unit_addr_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_row_streamer_if.sv
// Memory read port and unit/cache write ports of the mat row streamer.
interface mat_row_streamer_if #(
    parameter int unsigned WIDTH              = 16,
    parameter int unsigned ELEM_BITS          = mat_pkg::MAT_ELEM_BITS,
    parameter int unsigned DATA_MEM_ADDR_SIZE = 32,
    parameter int unsigned CACHE_SIZE         = 8,
    parameter int unsigned NUM_UNITS          = 2
);
    localparam int unsigned WIDTH_ADDR_SIZE = $clog2(WIDTH);
    localparam int unsigned CACHE_ADDR_SIZE = $clog2(CACHE_SIZE);
    localparam int unsigned DATA_W          = WIDTH * ELEM_BITS;

    logic                          mem_req;
    logic [DATA_MEM_ADDR_SIZE-1:0] mem_addr;
    logic [DATA_W-1:0]             mem_data;

    logic [NUM_UNITS-1:0]          unit_set_weight;
    logic [WIDTH_ADDR_SIZE-1:0]    unit_set_weight_row;
    logic [DATA_W-1:0]             unit_data;

    logic                          cache_write_en;
    logic [CACHE_ADDR_SIZE-1:0]    cache_write_addr;
    logic [WIDTH_ADDR_SIZE-1:0]    cache_write_row;
    logic [DATA_W-1:0]             cache_data;

    modport master (
        output mem_req, mem_addr,
        input  mem_data,
        output unit_set_weight, unit_set_weight_row, unit_data,
        output cache_write_en, cache_write_addr, cache_write_row, cache_data
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_data,
        input  unit_set_weight, unit_set_weight_row, unit_data,
        input  cache_write_en, cache_write_addr, cache_write_row, cache_data
    );

endinterface

// File: rtl/mat_req_tracker.sv
// Shift pipe tagging each outstanding memory read with its row index until data returns.
module mat_req_tracker #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ROW_BITS    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                push_valid,
    input  logic [ROW_BITS-1:0] push_row,
    output logic                pop_valid,
    output logic [ROW_BITS-1:0] pop_row
);
    localparam int unsigned PIPE_W = MEM_LATENCY * ROW_BITS;

    logic [MEM_LATENCY-1:0] valid_q;
    logic [PIPE_W-1:0]      row_q;

    // Stage 0 sits in the low bits; shifting left by one stage per edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            row_q   <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            valid_q <= MEM_LATENCY'({valid_q, push_valid});
            row_q   <= PIPE_W'({row_q, push_row});
        end
    end

    assign pop_valid = valid_q[MEM_LATENCY-1];
    assign pop_row   = row_q[PIPE_W-1 -: ROW_BITS];

endmodule

// File: rtl/mat_row_streamer.sv
// DMA-style sequencer streaming a strided block of matrix rows from data memory
// into the weight rows of one mat unit or into one cache entry.
module mat_row_streamer
    import mat_pkg::*;
#(
    parameter int unsigned WIDTH              = 16,
    parameter int unsigned ELEM_BITS          = MAT_ELEM_BITS,
    parameter int unsigned DATA_MEM_ADDR_SIZE = 32,
    parameter int unsigned CACHE_SIZE         = 8,
    parameter int unsigned NUM_UNITS          = 2,
    parameter int unsigned MEM_LATENCY        = 1,
    localparam int unsigned WIDTH_ADDR_SIZE   = $clog2(WIDTH),
    localparam int unsigned CACHE_ADDR_SIZE   = $clog2(CACHE_SIZE),
    localparam int unsigned UNIT_ADDR_SIZE    = mat_unit_addr_bits(NUM_UNITS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [DATA_MEM_ADDR_SIZE-1:0] cfg_base,
    input  logic [DATA_MEM_ADDR_SIZE-1:0] cfg_stride,
    input  logic [WIDTH_ADDR_SIZE:0]      cfg_rows,
    input  logic                          cfg_dest,
    input  logic [UNIT_ADDR_SIZE-1:0]     cfg_unit,
    input  logic [CACHE_ADDR_SIZE-1:0]    cfg_cache_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    mat_row_streamer_if.master            bus
);
    localparam int unsigned ROW_W  = WIDTH_ADDR_SIZE;
    localparam int unsigned CNT_W  = WIDTH_ADDR_SIZE + 1;
    localparam int unsigned DATA_W = WIDTH * ELEM_BITS;

    MatStreamState_t state_q, state_d;

    // Latched configuration
    MatStreamDest_t                dest_q;
    logic [CNT_W-1:0]              rows_q;
    logic [DATA_MEM_ADDR_SIZE-1:0] stride_q;
    logic [UNIT_ADDR_SIZE-1:0]     unit_q;
    logic [CACHE_ADDR_SIZE-1:0]    cache_addr_q;

    logic [DATA_MEM_ADDR_SIZE-1:0] addr_q;
    logic [ROW_W-1:0]              issue_row_q;
    logic                          err_q;

    logic                          wr_valid_q;
    logic [ROW_W-1:0]              wr_row_q;
    logic [NUM_UNITS-1:0]          unit_we_q;
    logic [ROW_W-1:0]              unit_row_q;
    logic [DATA_W-1:0]             unit_data_q;
    logic                          cache_we_q;
    logic [CACHE_ADDR_SIZE-1:0]    cache_waddr_q;
    logic [ROW_W-1:0]              cache_row_q;
    logic [DATA_W-1:0]             cache_data_q;

    logic                          cfg_legal;
    logic [31:0]                   unit_ext;
    logic [CNT_W-1:0]              rows_m1;
    logic                          active;
    logic                          last_req;
    logic                          last_wr;
    logic                          flush;
    logic                          pop_valid;
    logic [ROW_W-1:0]              pop_row;

    assign unit_ext = 32'(cfg_unit);

    always_comb begin
        cfg_legal = 1'b1;
        if (cfg_rows == '0 || cfg_rows > CNT_W'(WIDTH)) begin
            cfg_legal = 1'b0;
        end
        if (MatStreamDest_t'(cfg_dest) == MAT_DEST_UNIT && unit_ext >= 32'(NUM_UNITS)) begin
            cfg_legal = 1'b0;
        end
    end

    assign rows_m1  = rows_q - CNT_W'(1);
    assign active   = (state_q == ISSUE) || (state_q == DRAIN);
    assign last_req = (state_q == ISSUE) && (CNT_W'(issue_row_q) == rows_m1);
    // Writes leave in ascending row order, so the last row's write closes the transfer.
    assign last_wr  = wr_valid_q && (CNT_W'(wr_row_q) == rows_m1);
    assign flush    = active && abort;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = cfg_legal ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_wr) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mat_req_tracker #(
        .MEM_LATENCY (MEM_LATENCY),
        .ROW_BITS    (ROW_W)
    ) u_tracker (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push_valid (state_q == ISSUE),
        .push_row   (issue_row_q),
        .pop_valid  (pop_valid),
        .pop_row    (pop_row)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dest_q        <= MAT_DEST_UNIT;
            rows_q        <= '0;
            stride_q      <= '0;
            unit_q        <= '0;
            cache_addr_q  <= '0;
            addr_q        <= '0;
            issue_row_q   <= '0;
            err_q         <= 1'b0;
            wr_valid_q    <= 1'b0;
            wr_row_q      <= '0;
            unit_we_q     <= '0;
            unit_row_q    <= '0;
            unit_data_q   <= '0;
            cache_we_q    <= 1'b0;
            cache_waddr_q <= '0;
            cache_row_q   <= '0;
            cache_data_q  <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            unit_we_q  <= '0;
            cache_we_q <= 1'b0;

            if (state_q == IDLE && start) begin
                err_q        <= ~cfg_legal;
                dest_q       <= MatStreamDest_t'(cfg_dest);
                rows_q       <= cfg_rows;
                stride_q     <= cfg_stride;
                unit_q       <= cfg_unit;
                cache_addr_q <= cfg_cache_addr;
                addr_q       <= cfg_base;
                issue_row_q  <= '0;
            end else if (state_q == ISSUE && !abort) begin
                addr_q      <= addr_q + stride_q;
                issue_row_q <= issue_row_q + ROW_W'(1);
            end

            // Returning data is only written while a transfer is live; data outputs
            // of the untargeted port keep their previous contents.
            if (active && !abort && pop_valid) begin
                wr_valid_q <= 1'b1;
                wr_row_q   <= pop_row;
                if (dest_q == MAT_DEST_UNIT) begin
                    unit_we_q   <= NUM_UNITS'(1) << unit_q;
                    unit_row_q  <= pop_row;
                    unit_data_q <= bus.mem_data;
                end else begin
                    cache_we_q    <= 1'b1;
                    cache_waddr_q <= cache_addr_q;
                    cache_row_q   <= pop_row;
                    cache_data_q  <= bus.mem_data;
                end
            end
        end
    end

    assign busy = active;
    assign done = (state_q == DONE);
    assign err  = err_q;

    assign bus.mem_req             = (state_q == ISSUE);
    assign bus.mem_addr            = addr_q;
    assign bus.unit_set_weight     = unit_we_q;
    assign bus.unit_set_weight_row = unit_row_q;
    assign bus.unit_data           = unit_data_q;
    assign bus.cache_write_en      = cache_we_q;
    assign bus.cache_write_addr    = cache_waddr_q;
    assign bus.cache_write_row     = cache_row_q;
    assign bus.cache_data          = cache_data_q;

endmodule

// File: tb/tb_mat_row_streamer.sv
// Directed bench for mat_row_streamer: one instance with MEM_LATENCY=1, one with 3.
module tb_mat_row_streamer;
    localparam int unsigned W  = 16;
    localparam int unsigned EB = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned CS = 8;
    localparam int unsigned NU = 2;
    localparam int unsigned DW = W * EB;

    logic           clock;
    logic           reset;
    logic           start;
    logic           abort;
    logic           sel3;
    logic [AW-1:0]  cfg_base;
    logic [AW-1:0]  cfg_stride;
    logic [4:0]     cfg_rows;
    logic           cfg_dest;
    logic           cfg_unit;
    logic [2:0]     cfg_cache_addr;

    logic busy1, done1, err1, busy3, done3, err3;

    int checks = 0;
    int errors = 0;

    mat_row_streamer_if #(.WIDTH(W), .ELEM_BITS(EB), .DATA_MEM_ADDR_SIZE(AW),
                          .CACHE_SIZE(CS), .NUM_UNITS(NU)) if1 ();
    mat_row_streamer_if #(.WIDTH(W), .ELEM_BITS(EB), .DATA_MEM_ADDR_SIZE(AW),
                          .CACHE_SIZE(CS), .NUM_UNITS(NU)) if3 ();

    mat_row_streamer #(.WIDTH(W), .ELEM_BITS(EB), .DATA_MEM_ADDR_SIZE(AW),
                       .CACHE_SIZE(CS), .NUM_UNITS(NU), .MEM_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .start(start && !sel3), .abort(abort && !sel3),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_rows(cfg_rows),
        .cfg_dest(cfg_dest), .cfg_unit(cfg_unit), .cfg_cache_addr(cfg_cache_addr),
        .busy(busy1), .done(done1), .err(err1), .bus(if1)
    );

    mat_row_streamer #(.WIDTH(W), .ELEM_BITS(EB), .DATA_MEM_ADDR_SIZE(AW),
                       .CACHE_SIZE(CS), .NUM_UNITS(NU), .MEM_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .start(start && sel3), .abort(abort && sel3),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_rows(cfg_rows),
        .cfg_dest(cfg_dest), .cfg_unit(cfg_unit), .cfg_cache_addr(cfg_cache_addr),
        .busy(busy3), .done(done3), .err(err3), .bus(if3)
    );

    function automatic logic [DW-1:0] pat(input logic [31:0] a);
        logic [DW-1:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[j*32 +: 32] = {a[23:0], 8'(j)};
        end
        return r;
    endfunction

    // Memory model: returns pat(addr) exactly MEM_LATENCY cycles after each request.
    logic [DW-1:0] mdata1, mdata3;
    logic [AW-1:0] a3_0, a3_1;
    always @(posedge clock) begin
        mdata1 <= pat(if1.mem_addr);
        a3_0   <= if3.mem_addr;
        a3_1   <= a3_0;
        mdata3 <= pat(a3_1);
    end
    assign if1.mem_data = mdata1;
    assign if3.mem_data = mdata3;

    logic          s_busy, s_done, s_err, s_req, s_cwe;
    logic [AW-1:0] s_addr;
    logic [1:0]    s_uw;
    logic [3:0]    s_urow, s_crow;
    logic [2:0]    s_caddr;
    logic [DW-1:0] s_udata, s_cdata;

    always_comb begin
        s_busy  = sel3 ? busy3 : busy1;
        s_done  = sel3 ? done3 : done1;
        s_err   = sel3 ? err3  : err1;
        s_req   = sel3 ? if3.mem_req : if1.mem_req;
        s_addr  = sel3 ? if3.mem_addr : if1.mem_addr;
        s_uw    = sel3 ? if3.unit_set_weight : if1.unit_set_weight;
        s_urow  = sel3 ? if3.unit_set_weight_row : if1.unit_set_weight_row;
        s_udata = sel3 ? if3.unit_data : if1.unit_data;
        s_cwe   = sel3 ? if3.cache_write_en : if1.cache_write_en;
        s_caddr = sel3 ? if3.cache_write_addr : if1.cache_write_addr;
        s_crow  = sel3 ? if3.cache_write_row : if1.cache_write_row;
        s_cdata = sel3 ? if3.cache_data : if1.cache_data;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Full transfer with cycle-exact expectations; cycle 1 follows the start edge.
    task automatic xfer(input string name, input bit use3, input int unsigned lat,
                        input logic [31:0] base, input logic [31:0] stride,
                        input int unsigned rows, input bit dest, input logic unit,
                        input logic [2:0] caddr, input bit poke);
        logic [31:0]   exp_addr;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_uw;
        int unsigned   row;
        bit exp_req, exp_busy, exp_done, exp_wr, exp_cwe;
        sel3 = use3;
        cfg_base = base; cfg_stride = stride; cfg_rows = 5'(rows);
        cfg_dest = dest; cfg_unit = unit; cfg_cache_addr = caddr;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int unsigned c = 1; c <= rows + lat + 3; c++) begin
            @(negedge clock);
            exp_req  = (c <= rows);
            exp_busy = (c <= rows + lat + 1);
            exp_done = (c == rows + lat + 2);
            exp_wr   = (c >= lat + 2) && (c <= rows + lat + 1);
            row      = c - lat - 2;
            exp_addr = base + (c - 1) * stride;
            exp_data = pat(base + row * stride);
            exp_uw   = (exp_wr && !dest) ? (2'b01 << unit) : 2'b00;
            exp_cwe  = exp_wr && dest;
            checks++;
            if (s_busy !== exp_busy) begin
                errors++; $display("FAIL %s busy c%0d got %b exp %b", name, c, s_busy, exp_busy);
            end
            checks++;
            if (s_done !== exp_done) begin
                errors++; $display("FAIL %s done c%0d got %b exp %b", name, c, s_done, exp_done);
            end
            checks++;
            if (s_err !== 1'b0) begin
                errors++; $display("FAIL %s err c%0d got %b exp 0", name, c, s_err);
            end
            checks++;
            if (s_req !== exp_req) begin
                errors++; $display("FAIL %s mem_req c%0d got %b exp %b", name, c, s_req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (s_addr !== exp_addr) begin
                    errors++; $display("FAIL %s mem_addr c%0d got %h exp %h", name, c, s_addr, exp_addr);
                end
            end
            checks++;
            if (s_uw !== exp_uw) begin
                errors++; $display("FAIL %s unit_set_weight c%0d got %b exp %b", name, c, s_uw, exp_uw);
            end
            checks++;
            if (s_cwe !== exp_cwe) begin
                errors++; $display("FAIL %s cache_write_en c%0d got %b exp %b", name, c, s_cwe, exp_cwe);
            end
            if (exp_wr && dest) begin
                checks++;
                if (s_caddr !== caddr || s_crow !== 4'(row)) begin
                    errors++; $display("FAIL %s cache_addr/row c%0d got %0d/%0d exp %0d/%0d",
                                       name, c, s_caddr, s_crow, caddr, row);
                end
                checks++;
                if (s_cdata !== exp_data) begin
                    errors++; $display("FAIL %s cache_data c%0d got %h exp %h", name, c, s_cdata, exp_data);
                end
            end
            if (exp_wr && !dest) begin
                checks++;
                if (s_urow !== 4'(row)) begin
                    errors++; $display("FAIL %s unit_row c%0d got %0d exp %0d", name, c, s_urow, row);
                end
                checks++;
                if (s_udata !== exp_data) begin
                    errors++; $display("FAIL %s unit_data c%0d got %h exp %h", name, c, s_udata, exp_data);
                end
            end
            if (poke && c == 2) begin
                start = 1'b1;
                cfg_base = 32'h0000_0999;
            end
            if (poke && c == 3) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel3 = (s == 1);
            #1;
            checks++;
            if ({s_busy, s_done, s_err, s_req, s_cwe} !== 5'b0) begin
                errors++; $display("FAIL reset flags dut%0d got %b exp 00000", s, {s_busy, s_done, s_err, s_req, s_cwe});
            end
            checks++;
            if (s_addr !== '0 || s_uw !== 2'b00) begin
                errors++; $display("FAIL reset addr/uw dut%0d got %h/%b exp 0/00", s, s_addr, s_uw);
            end
        end
        sel3 = 1'b0;
    endtask

    task automatic test_unit_target();
        xfer("unit", 1'b0, 1, 32'h10, 32'h1, 4, 1'b0, 1'b1, 3'd0, 1'b1);
    endtask

    task automatic test_cache_target();
        xfer("cache", 1'b0, 1, 32'h100, 32'h10, 16, 1'b1, 1'b0, 3'd5, 1'b0);
    endtask

    task automatic test_illegal();
        int unsigned bad [2] = '{0, 17};
        sel3 = 1'b0;
        foreach (bad[i]) begin
            cfg_rows = 5'(bad[i]); cfg_dest = 1'b0; cfg_unit = 1'b0;
            cfg_base = 32'h20; cfg_stride = 32'h1;
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock);
            checks++;
            if ({s_done, s_err, s_busy, s_req} !== 4'b1100) begin
                errors++; $display("FAIL illegal%0d c1 done/err/busy/req got %b exp 1100", bad[i], {s_done, s_err, s_busy, s_req});
            end
            @(negedge clock);
            checks++;
            if ({s_done, s_err, s_busy, s_req} !== 4'b0100) begin
                errors++; $display("FAIL illegal%0d c2 done/err/busy/req got %b exp 0100", bad[i], {s_done, s_err, s_busy, s_req});
            end
            checks++;
            if (s_uw !== 2'b00 || s_cwe !== 1'b0) begin
                errors++; $display("FAIL illegal%0d strobes got %b/%b exp 00/0", bad[i], s_uw, s_cwe);
            end
        end
    endtask

    task automatic test_wrap();
        xfer("wrap", 1'b0, 1, 32'hFFFF_FFFE, 32'h1, 3, 1'b1, 1'b0, 3'd7, 1'b0);
    endtask

    task automatic test_abort();
        sel3 = 1'b1;
        cfg_base = 32'h40; cfg_stride = 32'h2; cfg_rows = 5'd6;
        cfg_dest = 1'b1; cfg_unit = 1'b0; cfg_cache_addr = 3'd3;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h40) begin
            errors++; $display("FAIL abort c1 req/addr got %b/%h exp 1/00000040", s_req, s_addr);
        end
        @(negedge clock);
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h42) begin
            errors++; $display("FAIL abort c2 req/addr got %b/%h exp 1/00000042", s_req, s_addr);
        end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        checks++;
        if ({s_busy, s_done, s_req, s_cwe, s_err} !== 5'b0 || s_uw !== 2'b00) begin
            errors++; $display("FAIL abort c3 busy/done/req/cwe/err got %b uw %b exp 00000 00",
                               {s_busy, s_done, s_req, s_cwe, s_err}, s_uw);
        end
        // Restart while the aborted reads are still returning.
        xfer("abort_restart", 1'b1, 3, 32'h200, 32'h1, 3, 1'b0, 1'b0, 3'd0, 1'b0);
        sel3 = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        sel3 = 1'b0;
        cfg_base = 32'h300; cfg_stride = 32'h1; cfg_rows = 5'd4;
        cfg_dest = 1'b0; cfg_unit = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (s_busy !== 1'b1 || s_req !== 1'b0) begin
            errors++; $display("FAIL rst_drain c5 busy/req got %b/%b exp 1/0", s_busy, s_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({s_busy, s_done, s_err, s_req, s_cwe} !== 5'b0 || s_uw !== 2'b00) begin
            errors++; $display("FAIL rst_drain flags got %b uw %b exp 00000 00", {s_busy, s_done, s_err, s_req, s_cwe}, s_uw);
        end
        checks++;
        if (s_addr !== '0 || s_urow !== 4'd0 || s_udata !== '0) begin
            errors++; $display("FAIL rst_drain unit outs got %h/%0d/%h exp 0", s_addr, s_urow, s_udata);
        end
        checks++;
        if (s_caddr !== 3'd0 || s_crow !== 4'd0 || s_cdata !== '0) begin
            errors++; $display("FAIL rst_drain cache outs got %0d/%0d/%h exp 0", s_caddr, s_crow, s_cdata);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if ({s_busy, s_done, s_req, s_cwe} !== 4'b0 || s_uw !== 2'b00) begin
                errors++; $display("FAIL rst_drain idle%0d got %b uw %b exp 0000 00", c, {s_busy, s_done, s_req, s_cwe}, s_uw);
            end
        end
        xfer("post_reset", 1'b0, 1, 32'h500, 32'h3, 5, 1'b1, 1'b0, 3'd2, 1'b0);
    endtask

    task automatic test_back_to_back();
        xfer("b2b_a", 1'b0, 1, 32'h700, 32'h0, 1, 1'b0, 1'b0, 3'd0, 1'b0);
        xfer("b2b_b", 1'b0, 1, 32'h800, 32'h4, 2, 1'b0, 1'b1, 3'd0, 1'b0);
        xfer("b2b_c", 1'b1, 3, 32'h900, 32'h8, 16, 1'b1, 1'b0, 3'd6, 1'b0);
        sel3 = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; abort = 1'b0; sel3 = 1'b0;
        cfg_base = '0; cfg_stride = '0; cfg_rows = '0;
        cfg_dest = 1'b0; cfg_unit = 1'b0; cfg_cache_addr = '0;
        repeat (2) @(negedge clock);
        test_reset();
        reset = 1'b1;
        @(negedge clock);
        test_unit_target();
        test_cache_target();
        test_illegal();
        test_wrap();
        test_abort();
        test_reset_mid_drain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mat_row_streamer.md
Name: mat_row_streamer

Overview:
- Parametrised DMA-style sequencer that moves a block of rows from the matrix data memory into either the weight rows of one of several mat units or one cache entry.
- Replaces ad-hoc row-by-row loading in the control FSM.
- Sits between the mat control FSM (start/config/done), the data memory read port, and the unit/cache write ports.
- Adds what the single-unit flow lacks: a multi-unit target, strided addressing, configurable row count and memory latency, and abort.

Parameters:
- WIDTH, 16, elements per row; also the maximum row count.
- ELEM_BITS, 32, bits per element (IEEE single, carried as raw bits).
- DATA_MEM_ADDR_SIZE, 32, data memory address width.
- CACHE_SIZE, 8, number of cache entries.
- NUM_UNITS, 2, number of mat units addressable as weight targets.
- MEM_LATENCY, 1, cycles from mem_req to valid mem_data (>=1).
- Derived: WIDTH_ADDR_SIZE = $clog2(WIDTH); CACHE_ADDR_SIZE = $clog2(CACHE_SIZE); UNIT_ADDR_SIZE = max(1, $clog2(NUM_UNITS)).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch a transfer; sampled only in IDLE.
- abort  in  1  cancel the current transfer.
- cfg_base  in  DATA_MEM_ADDR_SIZE  address of row 0.
- cfg_stride  in  DATA_MEM_ADDR_SIZE  address increment per row.
- cfg_rows  in  WIDTH_ADDR_SIZE+1  rows to move; legal range 1..WIDTH.
- cfg_dest  in  1  0 = unit weights, 1 = cache.
- cfg_unit  in  UNIT_ADDR_SIZE  target unit index.
- cfg_cache_addr  in  CACHE_ADDR_SIZE  target cache entry.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky illegal-config flag; cleared by the next accepted start.
- mem_req  out  1  read request valid.
- mem_addr  out  DATA_MEM_ADDR_SIZE  read address.
- mem_data  in  WIDTH*ELEM_BITS  read data, valid MEM_LATENCY cycles after the request.
- unit_set_weight  out  NUM_UNITS  one-hot weight-write strobe.
- unit_set_weight_row  out  WIDTH_ADDR_SIZE  weight row index.
- unit_data  out  WIDTH*ELEM_BITS  weight row data.
- cache_write_en  out  1  cache row-write strobe.
- cache_write_addr  out  CACHE_ADDR_SIZE  cache entry.
- cache_write_row  out  WIDTH_ADDR_SIZE  row within the entry.
- cache_data  out  WIDTH*ELEM_BITS  cache row data.

Behaviour:
- Reset (reset low, asynchronous): state IDLE. All outputs 0, including err. Tracker pipe cleared. Takes effect immediately, including mid-transfer; no done pulse follows.
- Configuration is latched on the start edge. Later cfg_* changes have no effect until the next start.
- start while busy is ignored.
- States and transitions:
  - IDLE: on start with a legal config, go to ISSUE.
  - ISSUE: on the edge after the last request, go to DRAIN.
  - DRAIN: on the edge after the last write cycle, go to DONE.
  - DONE: on the next edge, go to IDLE.
- Illegal config (cfg_rows == 0 or cfg_rows > WIDTH, or cfg_unit >= NUM_UNITS when cfg_dest = 0): no memory requests. err = 1 and done = 1 in the next cycle, then IDLE.
- ISSUE: one request per cycle. Request k (k = 0..N-1) is in cycle k+1 after the start edge, with mem_addr = cfg_base + k*cfg_stride, modulo 2^DATA_MEM_ADDR_SIZE (wrap is silent).
- Each request pushes {valid, row k} into a MEM_LATENCY-deep pipe.
- Row k data is sampled in cycle k+1+MEM_LATENCY. Write outputs are registered and asserted in cycle k+2+MEM_LATENCY, one write per cycle, rows in ascending order.
- Unit target: unit_set_weight[cfg_unit] = 1, all other bits 0; unit_set_weight_row = k; unit_data = row data. Cache outputs stay 0.
- Cache target: cache_write_en = 1, cache_write_addr = cfg_cache_addr, cache_write_row = k; unit strobes stay 0.
- Data outputs hold their last value when no strobe is asserted.
- busy is 1 from the cycle after the start edge through the last write cycle.
- done pulses in cycle N+MEM_LATENCY+2. busy is 0 in that cycle.
- abort: takes effect at the next edge. Return to IDLE, mem_req and all strobes drop, in-flight returns are discarded, no done pulse, err unchanged. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.

Decomposition:
- Shared package mat_pkg holds:
  - MatStreamDest_t enum (MAT_DEST_UNIT, MAT_DEST_CACHE);
  - MatStreamState_t enum (IDLE, ISSUE, DRAIN, DONE);
  - MAT_ELEM_BITS constant.
- One sub-module, mat_req_tracker: a parametrised MEM_LATENCY shift pipe of {valid, row index} with synchronous flush (abort) and async clear.

Test Plan:
- Unit target, base=0x10, stride=1, rows=4, unit=1, MEM_LATENCY=1: mem_addr 0x10..0x13 in cycles 1..4; unit_set_weight=2'b10 with rows 0..3 in cycles 3..6; done in cycle 7.
- Cache target, base=0x100, stride=16, rows=WIDTH=16, cache_addr=5: addresses step by 0x10; 16 cache writes to entry 5 with rows 0..15; data matches memory.
- Illegal configs: rows=0 -> err=1 and done next cycle, no mem_req. rows=17 -> same. Next legal start clears err.
- Wrap: base=0xFFFF_FFFE, stride=1, rows=3 -> mem_addr FFFF_FFFE, FFFF_FFFF, 0000_0000.
- Abort after 2 requests with MEM_LATENCY=3: no strobes after the abort edge, no done pulse, busy=0. A new start succeeds and is unaffected by stale returns.
- Reset asserted mid-DRAIN: all outputs 0 immediately; after release the block is IDLE and a fresh start completes normally.
